// File: rtl/denklem_cozucu.sv
// denklem_cozucu: finds the smallest x with A*x+C == y (mod 2^YW), one candidate per clock.
// f(x) is built incrementally in r_acc, so a single adder covers the whole search.
module denklem_cozucu #(
    parameter int XW = 3,
    parameter int YW = 5,
    parameter int A  = 3,
    parameter int C  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [YW-1:0] y_in,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [XW-1:0] x_out
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    localparam logic [YW-1:0] A_M = YW'(A);
    localparam logic [YW-1:0] C_M = YW'(C);
    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_x_cnt;
    logic [XW-1:0] r_x_out;
    logic [YW-1:0] r_acc;
    logic [YW-1:0] r_y_q;
    logic          r_found;
    logic          w_hit;
    logic          w_last;
    assign w_hit  = r_acc == r_y_q;
    assign w_last = r_x_cnt == '1;
    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE   ? (start ? SEARCH : IDLE) :
                 r_state == SEARCH ? ((w_hit || w_last) ? DONE : SEARCH) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x_cnt <= '0;
            r_acc   <= '0;
            r_y_q   <= '0;
            r_found <= 1'b0;
            r_x_out <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_y_q   <= y_in;
                r_x_cnt <= '0;
                r_acc   <= C_M;
            end
            // first hit wins, so the smallest x is reported even after a wrap
            if (r_state == SEARCH) begin
                if (w_hit) begin
                    r_found <= 1'b1;
                    r_x_out <= r_x_cnt;
                end else if (w_last) begin
                    r_found <= 1'b0;
                    r_x_out <= '0;
                end else begin
                    r_x_cnt <= r_x_cnt + 1'b1;
                    r_acc   <= r_acc + A_M;
                end
            end
        end
    end
    assign busy  = r_state == SEARCH;
    assign done  = r_state == DONE;
    assign found = r_found;
    assign x_out = r_x_out;
endmodule
